// File: rtl/ctrl_multiciclo_pkg.sv
// ctrl_multiciclo_pkg: shared definitions for the multi-cycle MIPS-subset control
// unit. Holds opcode/funct values, ALUOp class codes, datapath mux-select values,
// the FSM state type and the decoded-instruction payload. The ALU control unit and
// the datapath use the same constants.
package ctrl_multiciclo_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALUOP_W  = 4;
    localparam int unsigned SRC_B_W  = 2;
    localparam int unsigned PCSRC_W  = 2;
    localparam int unsigned REGDST_W = 2;
    localparam int unsigned M2R_W    = 2;

    // Operation classes handed to the ALU control unit
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 4'd0;
    localparam logic [ALUOP_W-1:0] ALUOP_ADDI  = 4'd1;
    localparam logic [ALUOP_W-1:0] ALUOP_ANDI  = 4'd2;
    localparam logic [ALUOP_W-1:0] ALUOP_ORI   = 4'd3;
    localparam logic [ALUOP_W-1:0] ALUOP_XORI  = 4'd4;
    localparam logic [ALUOP_W-1:0] ALUOP_BEQ   = 4'd5;
    localparam logic [ALUOP_W-1:0] ALUOP_BNE   = 4'd6;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTI  = 4'd7;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTIU = 4'd8;
    localparam logic [ALUOP_W-1:0] ALUOP_LUI   = 4'd9;
    localparam logic [ALUOP_W-1:0] ALUOP_LW    = 4'd10;
    localparam logic [ALUOP_W-1:0] ALUOP_SW    = 4'd11;
    localparam logic [ALUOP_W-1:0] ALUOP_J     = 4'd12;
    localparam logic [ALUOP_W-1:0] ALUOP_JAL   = 4'd13;

    // Primary opcodes, instr[31:26]
    localparam logic [OP_W-1:0] OP_R     = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    // R-type function codes, instr[5:0]
    localparam logic [FUNCT_W-1:0] FN_SLL  = 6'h00;
    localparam logic [FUNCT_W-1:0] FN_SRL  = 6'h02;
    localparam logic [FUNCT_W-1:0] FN_SRA  = 6'h03;
    localparam logic [FUNCT_W-1:0] FN_SLLV = 6'h04;
    localparam logic [FUNCT_W-1:0] FN_SRLV = 6'h06;
    localparam logic [FUNCT_W-1:0] FN_SRAV = 6'h07;
    localparam logic [FUNCT_W-1:0] FN_JR   = 6'h08;
    localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_XOR  = 6'h26;
    localparam logic [FUNCT_W-1:0] FN_NOR  = 6'h27;
    localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;
    localparam logic [FUNCT_W-1:0] FN_SLTU = 6'h2B;

    // Datapath mux selects
    localparam logic               SRC_A_PC      = 1'b0;
    localparam logic               SRC_A_REG     = 1'b1;
    localparam logic [SRC_B_W-1:0] SRC_B_REG     = 2'd0;
    localparam logic [SRC_B_W-1:0] SRC_B_FOUR    = 2'd1;
    localparam logic [SRC_B_W-1:0] SRC_B_IMM     = 2'd2;
    localparam logic [SRC_B_W-1:0] SRC_B_IMM_SH2 = 2'd3;

    localparam logic IORD_PC  = 1'b0;
    localparam logic IORD_ALU = 1'b1;

    localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'd0;
    localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [PCSRC_W-1:0] PCSRC_REG    = 2'd3;

    localparam logic [REGDST_W-1:0] REGDST_RT = 2'd0;
    localparam logic [REGDST_W-1:0] REGDST_RD = 2'd1;
    localparam logic [REGDST_W-1:0] REGDST_RA = 2'd2;

    localparam logic [M2R_W-1:0] M2R_ALUOUT = 2'd0;
    localparam logic [M2R_W-1:0] M2R_MDR    = 2'd1;
    localparam logic [M2R_W-1:0] M2R_PC     = 2'd2;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_WB_R     = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_WB_I     = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_WB_MEM   = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_JAL      = 4'd12,
        ST_JR       = 4'd13
    } state_e;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_JR      = 4'd1,
        CLS_ALUI    = 4'd2,
        CLS_LW      = 4'd3,
        CLS_SW      = 4'd4,
        CLS_BEQ     = 4'd5,
        CLS_BNE     = 4'd6,
        CLS_J       = 4'd7,
        CLS_JAL     = 4'd8,
        CLS_ILLEGAL = 4'd9
    } iclass_e;

    // Decoder result: instruction class, legality, and ALUOp for I-type ALU ops
    typedef struct packed {
        iclass_e              cls;
        logic                 legal;
        logic [ALUOP_W-1:0]   alui_op;
    } decode_t;

endpackage

// File: rtl/ctrl_multiciclo_decod_opcode.sv
// ctrl_multiciclo_decod_opcode: combinational instruction classifier.
// Ports:
//   opcode  in  6  instr[31:26]
//   funct   in  6  instr[5:0], only meaningful for opcode 0x00
//   dec_c   out    {class, legal, I-type ALUOp}; combinational
module ctrl_multiciclo_decod_opcode
    import ctrl_multiciclo_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output decode_t    dec_c
);

    // Classify the opcode; unsupported encodings fall through as illegal
    always_comb begin
        dec_c = '{cls: CLS_ILLEGAL, legal: 1'b0, alui_op: ALUOP_ADDI};
        case (opcode)
            OP_R: begin
                if (funct == FN_JR) begin
                    dec_c.cls   = CLS_JR;
                    dec_c.legal = 1'b1;
                end else begin
                    case (funct)
                        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR,
                        FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA,
                        FN_SLLV, FN_SRLV, FN_SRAV: begin
                            dec_c.cls   = CLS_R;
                            dec_c.legal = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            OP_ADDI: begin
                dec_c.cls = CLS_ALUI; dec_c.legal = 1'b1; dec_c.alui_op = ALUOP_ADDI;
            end
            OP_SLTI: begin
                dec_c.cls = CLS_ALUI; dec_c.legal = 1'b1; dec_c.alui_op = ALUOP_SLTI;
            end
            OP_SLTIU: begin
                dec_c.cls = CLS_ALUI; dec_c.legal = 1'b1; dec_c.alui_op = ALUOP_SLTIU;
            end
            OP_ANDI: begin
                dec_c.cls = CLS_ALUI; dec_c.legal = 1'b1; dec_c.alui_op = ALUOP_ANDI;
            end
            OP_ORI: begin
                dec_c.cls = CLS_ALUI; dec_c.legal = 1'b1; dec_c.alui_op = ALUOP_ORI;
            end
            OP_XORI: begin
                dec_c.cls = CLS_ALUI; dec_c.legal = 1'b1; dec_c.alui_op = ALUOP_XORI;
            end
            OP_LUI: begin
                dec_c.cls = CLS_ALUI; dec_c.legal = 1'b1; dec_c.alui_op = ALUOP_LUI;
            end
            OP_LW:  begin dec_c.cls = CLS_LW;  dec_c.legal = 1'b1; end
            OP_SW:  begin dec_c.cls = CLS_SW;  dec_c.legal = 1'b1; end
            OP_BEQ: begin dec_c.cls = CLS_BEQ; dec_c.legal = 1'b1; end
            OP_BNE: begin dec_c.cls = CLS_BNE; dec_c.legal = 1'b1; end
            OP_J:   begin dec_c.cls = CLS_J;   dec_c.legal = 1'b1; end
            OP_JAL: begin dec_c.cls = CLS_JAL; dec_c.legal = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_multiciclo.sv
// ctrl_multiciclo: multi-cycle main control FSM for the MIPS-subset core.
// Sequences fetch/decode/execute/memory/write-back, sharing one ALU and one
// memory port, and stalls in FETCH/MEM_RD/MEM_WR until mem_ready.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   opcode, funct      fields from the instruction register
//   zero               ALU zero flag (used in BRANCH)
//   mem_ready          memory completes the current access this cycle
//   ALUOp              operation class for the ALU control unit
//   alu_src_a/b, i_or_d, pc_source, reg_dst, mem_to_reg   datapath selects
//   mem_rd, mem_wr, ir_write, pc_write, reg_write          strobes/enables
//   illegal            one-cycle pulse in DECODE on unsupported encodings
// Outputs are decoded from the state register so that reset forces FETCH
// values immediately.
module ctrl_multiciclo
    import ctrl_multiciclo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] ALUOp,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       i_or_d,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       illegal
);

    state_e  state_q;
    state_e  state_d;
    decode_t dec;

    ctrl_multiciclo_decod_opcode u_decod (
        .opcode (opcode),
        .funct  (funct),
        .dec_c  (dec)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        ALUOp      = ALUOP_ADDI;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_REG;
        i_or_d     = IORD_PC;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = PCSRC_ALU;
        reg_write  = 1'b0;
        reg_dst    = REGDST_RT;
        mem_to_reg = M2R_ALUOUT;
        illegal    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = SRC_B_FOUR;
                // rst_n qualifies the loads so a ready memory cannot commit during reset
                ir_write  = mem_ready & rst_n;
                pc_write  = mem_ready & rst_n;
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // Branch target PC + (imm << 2) is precomputed into ALUOut here
                alu_src_b = SRC_B_IMM_SH2;
                if (!dec.legal) begin
                    illegal = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    case (dec.cls)
                        CLS_R:            state_d = ST_EXEC_R;
                        CLS_JR:           state_d = ST_JR;
                        CLS_ALUI:         state_d = ST_EXEC_I;
                        CLS_LW, CLS_SW:   state_d = ST_MEM_ADDR;
                        CLS_BEQ, CLS_BNE: state_d = ST_BRANCH;
                        CLS_J:            state_d = ST_JUMP;
                        CLS_JAL:          state_d = ST_JAL;
                        default: begin
                            illegal = 1'b1;
                            state_d = ST_FETCH;
                        end
                    endcase
                end
            end

            ST_EXEC_R: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_REG;
                ALUOp     = ALUOP_RTYPE;
                state_d   = ST_WB_R;
            end

            ST_WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RD;
                mem_to_reg = M2R_ALUOUT;
                state_d    = ST_FETCH;
            end

            ST_EXEC_I: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                ALUOp     = dec.alui_op;
                state_d   = ST_WB_I;
            end

            ST_WB_I: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RT;
                mem_to_reg = M2R_ALUOUT;
                state_d    = ST_FETCH;
            end

            ST_MEM_ADDR: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                if (dec.cls == CLS_SW) begin
                    ALUOp   = ALUOP_SW;
                    state_d = ST_MEM_WR;
                end else begin
                    ALUOp   = ALUOP_LW;
                    state_d = ST_MEM_RD;
                end
            end

            ST_MEM_RD: begin
                mem_rd = 1'b1;
                i_or_d = IORD_ALU;
                if (mem_ready) begin
                    state_d = ST_WB_MEM;
                end
            end

            ST_WB_MEM: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RT;
                mem_to_reg = M2R_MDR;
                state_d    = ST_FETCH;
            end

            ST_MEM_WR: begin
                mem_wr = 1'b1;
                i_or_d = IORD_ALU;
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end
            end

            ST_BRANCH: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_REG;
                pc_source = PCSRC_ALUOUT;
                if (dec.cls == CLS_BNE) begin
                    ALUOp    = ALUOP_BNE;
                    pc_write = ~zero;
                end else begin
                    ALUOp    = ALUOP_BEQ;
                    pc_write = zero;
                end
                state_d = ST_FETCH;
            end

            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                state_d   = ST_FETCH;
            end

            ST_JAL: begin
                // Link: $31 <= PC (already PC+4 after fetch)
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                reg_write  = 1'b1;
                reg_dst    = REGDST_RA;
                mem_to_reg = M2R_PC;
                state_d    = ST_FETCH;
            end

            ST_JR: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_REG;
                state_d   = ST_FETCH;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// tb_ctrl_multiciclo: self-checking bench for ctrl_multiciclo. Directed table of
// per-instruction vectors, hand sequences for stalls and reset, and random
// instruction streams checked cycle by cycle against a per-instruction step list.
module tb_ctrl_multiciclo;

    typedef struct packed {
        logic [3:0] aluop;
        logic       src_a;
        logic [1:0] src_b;
        logic       i_or_d;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       illegal;
    } outs_t;

    typedef struct {
        outs_t o;
        bit    waits;
    } step_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         cycles;
        outs_t      exp3;
        outs_t      expl;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] ALUOp;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       i_or_d;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal;

    int errors = 0;
    int checks = 0;

    step_t exp_q[$];
    vec_t  vt[$];

    ctrl_multiciclo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ALUOp      (ALUOp),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .i_or_d     (i_or_d),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    function automatic outs_t cur();
        outs_t o;
        o.aluop = ALUOp;      o.src_a = alu_src_a;   o.src_b = alu_src_b;
        o.i_or_d = i_or_d;    o.mem_rd = mem_rd;     o.mem_wr = mem_wr;
        o.ir_write = ir_write; o.pc_write = pc_write; o.pc_source = pc_source;
        o.reg_write = reg_write; o.reg_dst = reg_dst; o.mem_to_reg = mem_to_reg;
        o.illegal = illegal;
        return o;
    endfunction

    function automatic outs_t mk(input int aluop, input int sa, input int sb, input int iod,
                                 input int mrd, input int mwr, input int irw, input int pcw,
                                 input int pcs, input int rw, input int rd, input int m2r,
                                 input int ill);
        outs_t o;
        o.aluop = 4'(aluop);   o.src_a = 1'(sa);      o.src_b = 2'(sb);
        o.i_or_d = 1'(iod);    o.mem_rd = 1'(mrd);    o.mem_wr = 1'(mwr);
        o.ir_write = 1'(irw);  o.pc_write = 1'(pcw);  o.pc_source = 2'(pcs);
        o.reg_write = 1'(rw);  o.reg_dst = 2'(rd);    o.mem_to_reg = 2'(m2r);
        o.illegal = 1'(ill);
        return o;
    endfunction

    task automatic chk(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // ---------------- reference model: instruction -> list of cycle outputs ----
    function automatic bit funct_ok(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
    endfunction

    function automatic bit op_ok(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return funct_ok(fn);
        return op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0B,
                          6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    endfunction

    function automatic int imm_class(input logic [5:0] op);
        case (op)
            6'h08: return 1;  6'h0A: return 7;  6'h0B: return 8;  6'h0C: return 2;
            6'h0D: return 3;  6'h0E: return 4;  6'h0F: return 9;
            default: return -1;
        endcase
    endfunction

    task automatic push(input outs_t o, input bit w);
        step_t s;
        s.o = o;
        s.waits = w;
        exp_q.push_back(s);
    endtask

    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
        exp_q.delete();
        push(mk(1,0,1,0, 1,0,1,1, 0,0,0,0,0), 1'b1);              // instruction fetch
        if (!op_ok(op, fn)) begin
            push(mk(1,0,3,0, 0,0,0,0, 0,0,0,0,1), 1'b0);
            return;
        end
        push(mk(1,0,3,0, 0,0,0,0, 0,0,0,0,0), 1'b0);              // decode
        if (op == 6'h00 && fn == 6'h08) begin
            push(mk(1,0,0,0, 0,0,0,1, 3,0,0,0,0), 1'b0);
        end else if (op == 6'h00) begin
            push(mk(0,1,0,0, 0,0,0,0, 0,0,0,0,0), 1'b0);
            push(mk(1,0,0,0, 0,0,0,0, 0,1,1,0,0), 1'b0);
        end else if (imm_class(op) >= 0) begin
            push(mk(imm_class(op),1,2,0, 0,0,0,0, 0,0,0,0,0), 1'b0);
            push(mk(1,0,0,0, 0,0,0,0, 0,1,0,0,0), 1'b0);
        end else if (op == 6'h23) begin
            push(mk(10,1,2,0, 0,0,0,0, 0,0,0,0,0), 1'b0);
            push(mk(1,0,0,1, 1,0,0,0, 0,0,0,0,0), 1'b1);
            push(mk(1,0,0,0, 0,0,0,0, 0,1,0,1,0), 1'b0);
        end else if (op == 6'h2B) begin
            push(mk(11,1,2,0, 0,0,0,0, 0,0,0,0,0), 1'b0);
            push(mk(1,0,0,1, 0,1,0,0, 0,0,0,0,0), 1'b1);
        end else if (op == 6'h04 || op == 6'h05) begin
            bit taken = (op == 6'h04) ? z : !z;
            push(mk((op == 6'h04) ? 5 : 6,1,0,0, 0,0,0,int'(taken), 1,0,0,0,0), 1'b0);
        end else if (op == 6'h02) begin
            push(mk(1,0,0,0, 0,0,0,1, 2,0,0,0,0), 1'b0);
        end else begin
            push(mk(1,0,0,0, 0,0,0,1, 2,1,2,2,0), 1'b0);          // jal
        end
    endtask

    // Runs one instruction from FETCH; sf/sm = wait cycles in fetch / data access,
    // negative means random 0..3. Returns with the DUT back in FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int sf, input int sm, input string tag);
        outs_t st;
        int    ns;
        opcode = op;
        funct  = fn;
        build(op, fn, z);
        for (int i = 0; i < exp_q.size(); i++) begin
            ns = 0;
            if (exp_q[i].waits) begin
                ns = (i == 0) ? sf : sm;
                if (ns < 0) ns = int'($urandom_range(0, 3));
            end
            for (int s = 0; s < ns; s++) begin
                zero = z;
                mem_ready = 1'b0;
                st = exp_q[i].o;
                st.ir_write = 1'b0;
                st.pc_write = 1'b0;
                @(negedge clk);
                chk($sformatf("%s op%02h fn%02h step%0d wait%0d", tag, op, fn, i, s), cur(), st);
                @(posedge clk); #1;
            end
            zero = z;
            mem_ready = exp_q[i].waits ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            chk($sformatf("%s op%02h fn%02h step%0d", tag, op, fn, i), cur(), exp_q[i].o);
            @(posedge clk); #1;
        end
    endtask

    task automatic addv(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input int cyc, input outs_t e3, input outs_t el);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.cycles = cyc; v.exp3 = e3; v.expl = el;
        vt.push_back(v);
    endtask

    localparam logic [5:0] RAND_OPS [16] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                                             6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                                             6'h0F, 6'h23, 6'h2B, 6'h3F};
    localparam logic [5:0] RAND_FNS [16] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                                             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04,
                                             6'h06, 6'h07, 6'h08, 6'h01};

    initial begin
        outs_t f_stall, alu_wb_rd, alu_wb_rt;
        logic [5:0] op, fn;
        f_stall   = mk(1,0,1,0, 1,0,0,0, 0,0,0,0,0);
        alu_wb_rd = mk(1,0,0,0, 0,0,0,0, 0,1,1,0,0);
        alu_wb_rt = mk(1,0,0,0, 0,0,0,0, 0,1,0,0,0);

        // {opcode, funct, zero, cycles, 3rd-cycle outputs, last-cycle outputs}
        addv(6'h00, 6'h20, 1'b0, 4, mk(0,1,0,0, 0,0,0,0, 0,0,0,0,0), alu_wb_rd);
        addv(6'h00, 6'h22, 1'b1, 4, mk(0,1,0,0, 0,0,0,0, 0,0,0,0,0), alu_wb_rd);
        addv(6'h00, 6'h00, 1'b0, 4, mk(0,1,0,0, 0,0,0,0, 0,0,0,0,0), alu_wb_rd);
        addv(6'h08, 6'h3F, 1'b0, 4, mk(1,1,2,0, 0,0,0,0, 0,0,0,0,0), alu_wb_rt);
        addv(6'h0A, 6'h00, 1'b0, 4, mk(7,1,2,0, 0,0,0,0, 0,0,0,0,0), alu_wb_rt);
        addv(6'h0B, 6'h00, 1'b0, 4, mk(8,1,2,0, 0,0,0,0, 0,0,0,0,0), alu_wb_rt);
        addv(6'h0C, 6'h00, 1'b0, 4, mk(2,1,2,0, 0,0,0,0, 0,0,0,0,0), alu_wb_rt);
        addv(6'h0D, 6'h00, 1'b0, 4, mk(3,1,2,0, 0,0,0,0, 0,0,0,0,0), alu_wb_rt);
        addv(6'h0E, 6'h00, 1'b0, 4, mk(4,1,2,0, 0,0,0,0, 0,0,0,0,0), alu_wb_rt);
        addv(6'h0F, 6'h00, 1'b0, 4, mk(9,1,2,0, 0,0,0,0, 0,0,0,0,0), alu_wb_rt);
        addv(6'h23, 6'h00, 1'b0, 5, mk(10,1,2,0, 0,0,0,0, 0,0,0,0,0),
             mk(1,0,0,0, 0,0,0,0, 0,1,0,1,0));
        addv(6'h2B, 6'h00, 1'b0, 4, mk(11,1,2,0, 0,0,0,0, 0,0,0,0,0),
             mk(1,0,0,1, 0,1,0,0, 0,0,0,0,0));
        addv(6'h04, 6'h00, 1'b1, 3, mk(5,1,0,0, 0,0,0,1, 1,0,0,0,0), mk(5,1,0,0, 0,0,0,1, 1,0,0,0,0));
        addv(6'h04, 6'h00, 1'b0, 3, mk(5,1,0,0, 0,0,0,0, 1,0,0,0,0), mk(5,1,0,0, 0,0,0,0, 1,0,0,0,0));
        addv(6'h05, 6'h00, 1'b0, 3, mk(6,1,0,0, 0,0,0,1, 1,0,0,0,0), mk(6,1,0,0, 0,0,0,1, 1,0,0,0,0));
        addv(6'h05, 6'h00, 1'b1, 3, mk(6,1,0,0, 0,0,0,0, 1,0,0,0,0), mk(6,1,0,0, 0,0,0,0, 1,0,0,0,0));
        addv(6'h02, 6'h00, 1'b0, 3, mk(1,0,0,0, 0,0,0,1, 2,0,0,0,0), mk(1,0,0,0, 0,0,0,1, 2,0,0,0,0));
        addv(6'h03, 6'h00, 1'b0, 3, mk(1,0,0,0, 0,0,0,1, 2,1,2,2,0), mk(1,0,0,0, 0,0,0,1, 2,1,2,2,0));
        addv(6'h00, 6'h08, 1'b0, 3, mk(1,0,0,0, 0,0,0,1, 3,0,0,0,0), mk(1,0,0,0, 0,0,0,1, 3,0,0,0,0));
        addv(6'h3F, 6'h00, 1'b0, 2, f_stall, mk(1,0,3,0, 0,0,0,0, 0,0,0,0,1));
        addv(6'h00, 6'h01, 1'b0, 2, f_stall, mk(1,0,3,0, 0,0,0,0, 0,0,0,0,1));

        // Reset: FETCH values with loads held off even though memory is ready
        rst_n = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        #3;
        chk("reset_async", cur(), f_stall);
        @(posedge clk); #1;
        chk("reset_hold", cur(), f_stall);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk); #1;

        // Directed table, zero-wait memory
        for (int k = 0; k < vt.size(); k++) begin
            opcode = vt[k].op;
            funct  = vt[k].fn;
            zero   = vt[k].z;
            for (int c = 1; c <= vt[k].cycles + 1; c++) begin
                mem_ready = (c <= vt[k].cycles) ? 1'b1 : 1'b0;
                @(negedge clk);
                if (c == 3)
                    chk($sformatf("vec%0d cycle3", k), cur(), vt[k].exp3);
                if (c == vt[k].cycles)
                    chk($sformatf("vec%0d last", k), cur(), vt[k].expl);
                if (c == vt[k].cycles + 1)
                    chk($sformatf("vec%0d back_to_fetch", k), cur(), f_stall);
                @(posedge clk); #1;
            end
        end

        // lw with two wait cycles in the data read (7 cycles), then stalled fetch
        run_instr(6'h23, 6'h00, 1'b0, 0, 2, "lw_wait2");
        run_instr(6'h00, 6'h20, 1'b0, 3, 0, "add_fetch_wait3");
        run_instr(6'h2B, 6'h00, 1'b0, 1, 3, "sw_wait3");

        // Reset in the middle of a stalled store
        opcode = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk1("memwr_before_reset", mem_wr, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("reset_drops_mem_wr", mem_wr, 1'b0);
        chk("reset_mid_store", cur(), f_stall);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Random instruction stream
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
            else                           op = RAND_OPS[$urandom_range(0, 15)];
            if ($urandom_range(0, 7) == 0) fn = 6'($urandom_range(0, 63));
            else                           fn = RAND_FNS[$urandom_range(0, 15)];
            run_instr(op, fn, 1'($urandom_range(0, 1)), -1, -1, "rand");
        end

        mem_ready = 1'b0;
        @(negedge clk);
        chk("final_fetch", cur(), f_stall);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
